// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types and helpers for the pattern-history-table branch predictor.
// Outcome/mode enums plus the saturating counter update.
package branch_predictor_gshare_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef enum logic {
    PRED_BIMODAL = 1'b0,
    PRED_GSHARE  = 1'b1
  } PredMode;

  typedef enum logic {
    PHT_INIT = 1'b0,
    PHT_RUN  = 1'b1
  } pht_state_e;

  function automatic logic [3:0] sat_update(
    input logic [3:0]  ctr,
    input logic        taken,
    input int unsigned bits
  );
    logic [3:0] top;
    top = 4'((32'd1 << bits) - 32'd1);
    if (taken)
      sat_update = (ctr == top) ? ctr : ctr + 4'd1;
    else
      sat_update = (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Decode-request / EX-feedback bundle for the branch predictor.
// master = pipeline side, slave = predictor.
interface branch_predictor_gshare_if;
  import branch_predictor_gshare_pkg::*;

  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] req_target;
  BranchOutcome          req_prediction;
  logic                  fb_valid;
  logic [ADDR_WIDTH-1:0] fb_pc;
  BranchOutcome          fb_prediction;
  BranchOutcome          fb_outcome;

  modport master (
    output req_valid, req_pc, req_target,
    input  req_prediction,
    output fb_valid, fb_pc,
    output fb_prediction, fb_outcome
  );

  modport slave (
    input  req_valid, req_pc, req_target,
    output req_prediction,
    input  fb_valid, fb_pc,
    input  fb_prediction, fb_outcome
  );

endinterface

// File: rtl/branch_predictor_gshare_pht.sv
// Pattern history table: counter array, comb read, RMW update port,
// and the post-reset sweep that loads every entry with weakly-not-taken.
module branch_predictor_gshare_pht
  import branch_predictor_gshare_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  output logic                  init_done
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [INDEX_BITS-1:0] LAST =
    INDEX_BITS'(ENTRIES - 1);

  pht_state_e            state, state_next;
  logic [INDEX_BITS-1:0] ptr, ptr_next;
  logic [CTR_BITS-1:0]   ctr_mem [ENTRIES];
  logic [CTR_BITS-1:0]   upd_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PHT_INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    unique case (state)
      PHT_INIT: begin
        ptr_next = ptr + INDEX_BITS'(1);
        if (ptr == LAST)
          state_next = PHT_RUN;
      end
      PHT_RUN:  state_next = PHT_RUN;
      default:  state_next = PHT_INIT;
    endcase
  end

  assign upd_ctr = CTR_BITS'(sat_update(
    4'(ctr_mem[upd_idx]), upd_taken, CTR_BITS));

  // Sweep owns the write port until the table is fully cleared.
  always_ff @(posedge clk) begin
    if (state == PHT_INIT)
      ctr_mem[ptr] <= CTR_INIT;
    else if (upd_en)
      ctr_mem[upd_idx] <= upd_ctr;
  end

  assign rd_ctr    = ctr_mem[rd_idx];
  assign init_done = (state == PHT_RUN);

endmodule

// File: rtl/branch_predictor_gshare.sv
// Bimodal / gshare branch predictor: index hash, global history,
// accuracy statistics and request/feedback glue around the PHT.
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int      INDEX_BITS = 8,
  parameter int      HIST_BITS  = 8,
  parameter int      CTR_BITS   = 2,
  parameter PredMode MODE       = PRED_GSHARE,
  parameter int      STAT_BITS  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  branch_predictor_gshare_if.slave bus,
  output logic                    init_done,
  output logic [STAT_BITS-1:0]    fb_count,
  output logic [STAT_BITS-1:0]    mispred_count
);

  generate
    if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_hist
      $error("HIST_BITS must be in 1..INDEX_BITS");
    end
    if (CTR_BITS < 2 || CTR_BITS > 4) begin : g_bad_ctr
      $error("CTR_BITS must be in 2..4");
    end
  endgenerate

  logic [HIST_BITS-1:0]  ghr;
  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] fb_idx;
  logic [CTR_BITS-1:0]   req_ctr;
  logic                  train;
  logic                  fb_taken;
  logic                  mispred;
  logic                  unused_bits;

  function automatic logic [INDEX_BITS-1:0] hash(
    input logic [ADDR_WIDTH-1:0] pc,
    input logic [HIST_BITS-1:0]  h
  );
    logic [INDEX_BITS-1:0] pcidx;
    pcidx = pc[INDEX_BITS+1:2];
    if (MODE == PRED_GSHARE)
      hash = pcidx ^ INDEX_BITS'(h);
    else
      hash = pcidx;
  endfunction

  assign req_idx  = hash(bus.req_pc, ghr);
  assign fb_idx   = hash(bus.fb_pc, ghr);
  assign train    = init_done && bus.fb_valid;
  assign fb_taken = (bus.fb_outcome == TAKEN);
  assign mispred  = (bus.fb_prediction != bus.fb_outcome);

  assign bus.req_prediction =
    (bus.req_valid && init_done && req_ctr[CTR_BITS-1])
      ? TAKEN : NOT_TAKEN;

  branch_predictor_gshare_pht #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS)
  ) u_pht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (req_idx),
    .rd_ctr    (req_ctr),
    .upd_en    (train),
    .upd_idx   (fb_idx),
    .upd_taken (fb_taken),
    .init_done (init_done)
  );

  // History is trained from EX, so it is never speculative.
  generate
    if (HIST_BITS == 1) begin : g_hist1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ghr <= '0;
        else if (train)
          ghr <= fb_taken;
      end
    end else begin : g_histn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ghr <= '0;
        else if (train)
          ghr <= {ghr[HIST_BITS-2:0], fb_taken};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_count      <= '0;
      mispred_count <= '0;
    end else if (train) begin
      if (fb_count != '1)
        fb_count <= fb_count + STAT_BITS'(1);
      if (mispred && mispred_count != '1)
        mispred_count <= mispred_count + STAT_BITS'(1);
    end
  end

  assign unused_bits = ^{
    bus.req_target,
    bus.req_pc[ADDR_WIDTH-1:INDEX_BITS+2],
    bus.req_pc[1:0],
    bus.fb_pc[ADDR_WIDTH-1:INDEX_BITS+2],
    bus.fb_pc[1:0]
  };

  a_fb_outcome_known: assert property (
    @(posedge clk) disable iff (!rst_n)
    train |-> !$isunknown(bus.fb_outcome)
  ) else $error("unknown outcome on valid feedback");

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: gshare, bimodal and 4-bit-stat predictors share one
// request/feedback stimulus stream; each task checks its own feature.
module tb_branch_predictor_gshare;
  import branch_predictor_gshare_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [31:0]  req_pc = '0;
  logic [31:0]  req_target = '0;
  logic         fb_valid = 1'b0;
  logic [31:0]  fb_pc = '0;
  BranchOutcome fb_prediction = NOT_TAKEN;
  BranchOutcome fb_outcome = NOT_TAKEN;

  int n_chk = 0;
  int n_fail = 0;

  logic        gs_done, bi_done, st_done;
  logic [31:0] gs_fb, gs_mp, bi_fb, bi_mp;
  logic [3:0]  st_fb, st_mp;

  always #5 clk = ~clk;

  branch_predictor_gshare_if gs_if ();
  branch_predictor_gshare_if bi_if ();
  branch_predictor_gshare_if st_if ();

  assign gs_if.req_valid = req_valid;
  assign gs_if.req_pc = req_pc;
  assign gs_if.req_target = req_target;
  assign gs_if.fb_valid = fb_valid;
  assign gs_if.fb_pc = fb_pc;
  assign gs_if.fb_prediction = fb_prediction;
  assign gs_if.fb_outcome = fb_outcome;

  assign bi_if.req_valid = req_valid;
  assign bi_if.req_pc = req_pc;
  assign bi_if.req_target = req_target;
  assign bi_if.fb_valid = fb_valid;
  assign bi_if.fb_pc = fb_pc;
  assign bi_if.fb_prediction = fb_prediction;
  assign bi_if.fb_outcome = fb_outcome;

  assign st_if.req_valid = req_valid;
  assign st_if.req_pc = req_pc;
  assign st_if.req_target = req_target;
  assign st_if.fb_valid = fb_valid;
  assign st_if.fb_pc = fb_pc;
  assign st_if.fb_prediction = fb_prediction;
  assign st_if.fb_outcome = fb_outcome;

  branch_predictor_gshare u_gs (
    .clk (clk), .rst_n (rst_n), .bus (gs_if),
    .init_done (gs_done),
    .fb_count (gs_fb), .mispred_count (gs_mp)
  );

  branch_predictor_gshare #(.MODE(PRED_BIMODAL)) u_bi (
    .clk (clk), .rst_n (rst_n), .bus (bi_if),
    .init_done (bi_done),
    .fb_count (bi_fb), .mispred_count (bi_mp)
  );

  branch_predictor_gshare #(
    .MODE(PRED_BIMODAL), .STAT_BITS(4)
  ) u_st (
    .clk (clk), .rst_n (rst_n), .bus (st_if),
    .init_done (st_done),
    .fb_count (st_fb), .mispred_count (st_mp)
  );

  task automatic do_req(input logic [31:0] pc);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc = pc;
    fb_valid = 1'b0;
    #1;
  endtask

  task automatic do_fb(
    input logic [31:0] pc,
    input BranchOutcome pred,
    input BranchOutcome outc
  );
    @(negedge clk);
    req_valid = 1'b0;
    fb_valid = 1'b1;
    fb_pc = pc;
    fb_prediction = pred;
    fb_outcome = outc;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    fb_valid = 1'b0;
    #1;
  endtask

  task automatic run_sweep(input string name);
    int rise;
    bit bad_pred;
    rise = 0;
    bad_pred = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 300 && rise == 0; c++) begin
      @(posedge clk);
      #1;
      if (gs_done === 1'b1)
        rise = c;
      else if (gs_if.req_prediction !== NOT_TAKEN ||
               bi_if.req_prediction !== NOT_TAKEN)
        bad_pred = 1'b1;
    end
    n_chk++;
    if (rise != 256) begin
      n_fail++;
      $display("FAIL %s_done: got done after %0d clocks, expected 256",
               name, rise);
    end
    n_chk++;
    if (bad_pred) begin
      n_fail++;
      $display("FAIL %s_pred: got TAKEN during sweep, expected NOT_TAKEN",
               name);
    end
    n_chk++;
    if (bi_done !== 1'b1 || st_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_all: got %b/%b, expected 1/1",
               name, bi_done, st_done);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_pc = 32'h700;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (gs_done !== 1'b0 || bi_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b/%b, expected 0/0",
               gs_done, bi_done);
    end
    n_chk++;
    if (gs_fb !== 32'd0 || gs_mp !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0d/%0d, expected 0/0",
               gs_fb, gs_mp);
    end
    n_chk++;
    if (gs_if.req_prediction !== NOT_TAKEN) begin
      n_fail++;
      $display("FAIL reset_pred: got %0d, expected NOT_TAKEN(0)",
               gs_if.req_prediction);
    end
    run_sweep("sweep");
  endtask

  task automatic test_stat_sat();
    for (int i = 0; i < 15; i++)
      do_fb(32'h600, TAKEN, NOT_TAKEN);
    idle();
    n_chk++;
    if (st_fb !== 4'd15 || st_mp !== 4'd15) begin
      n_fail++;
      $display("FAIL stat_15: got %0d/%0d, expected 15/15",
               st_fb, st_mp);
    end
    for (int i = 0; i < 5; i++)
      do_fb(32'h600, TAKEN, NOT_TAKEN);
    idle();
    n_chk++;
    if (st_fb !== 4'd15 || st_mp !== 4'd15) begin
      n_fail++;
      $display("FAIL stat_sat: got %0d/%0d, expected 15/15",
               st_fb, st_mp);
    end
    n_chk++;
    if (bi_fb !== 32'd20 || bi_mp !== 32'd20) begin
      n_fail++;
      $display("FAIL stat_32: got %0d/%0d, expected 20/20",
               bi_fb, bi_mp);
    end
  endtask

  task automatic check_bi(input string name, input BranchOutcome exp);
    do_req(32'h400);
    n_chk++;
    if (bi_if.req_prediction !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, bi_if.req_prediction, exp);
    end
  endtask

  task automatic test_bimodal();
    check_bi("bim_init", NOT_TAKEN);
    do_fb(32'h400, NOT_TAKEN, TAKEN);
    check_bi("bim_t1", TAKEN);
    do_fb(32'h400, TAKEN, TAKEN);
    check_bi("bim_t2", TAKEN);
    for (int i = 0; i < 4; i++)
      do_fb(32'h400, TAKEN, TAKEN);
    do_fb(32'h400, TAKEN, NOT_TAKEN);
    check_bi("bim_sat_n1", TAKEN);
    do_fb(32'h400, TAKEN, NOT_TAKEN);
    check_bi("bim_sat_n2", NOT_TAKEN);
    idle();
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    req_valid = 1'b1;
    req_pc = 32'h700;
    fb_valid = 1'b1;
    fb_pc = 32'h700;
    fb_prediction = NOT_TAKEN;
    fb_outcome = TAKEN;
    #1;
    n_chk++;
    if (bi_if.req_prediction !== NOT_TAKEN) begin
      n_fail++;
      $display("FAIL same_cycle_old: got %0d, expected 0",
               bi_if.req_prediction);
    end
    @(negedge clk);
    fb_valid = 1'b0;
    #1;
    n_chk++;
    if (bi_if.req_prediction !== TAKEN) begin
      n_fail++;
      $display("FAIL same_cycle_new: got %0d, expected 1",
               bi_if.req_prediction);
    end
    idle();
  endtask

  task automatic test_gshare_loop();
    logic [31:0]  mp_base;
    BranchOutcome pred;
    BranchOutcome outc;
    mp_base = '0;
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 4; k++) begin
        outc = (k == 3) ? NOT_TAKEN : TAKEN;
        do_req(32'h500);
        pred = gs_if.req_prediction;
        if (it == 12 && k == 0)
          mp_base = gs_mp;
        if (it >= 12) begin
          n_chk++;
          if (pred !== outc) begin
            n_fail++;
            $display("FAIL gshare_pred it%0d k%0d: got %0d, expected %0d",
                     it, k, pred, outc);
          end
        end
        do_fb(32'h500, pred, outc);
      end
    end
    idle();
    n_chk++;
    if (gs_mp - mp_base !== 32'd0) begin
      n_fail++;
      $display("FAIL gshare_mispred_delta: got %0d, expected 0",
               gs_mp - mp_base);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_pc = 32'h700;
    #1;
    n_chk++;
    if (gs_fb !== 32'd0 || gs_mp !== 32'd0 || bi_fb !== 32'd0) begin
      n_fail++;
      $display("FAIL rerst_counts: got %0d/%0d/%0d, expected 0/0/0",
               gs_fb, gs_mp, bi_fb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    n_chk++;
    if (gs_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_sweep_done: got %b, expected 0", gs_done);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (gs_done !== 1'b0 || bi_if.req_prediction !== NOT_TAKEN) begin
      n_fail++;
      $display("FAIL pulse_state: got done=%b pred=%0d, expected 0/0",
               gs_done, bi_if.req_prediction);
    end
    req_valid = 1'b1;
    run_sweep("resweep");
    do_req(32'h700);
    n_chk++;
    if (bi_if.req_prediction !== NOT_TAKEN) begin
      n_fail++;
      $display("FAIL resweep_table: got %0d, expected 0",
               bi_if.req_prediction);
    end
    n_chk++;
    if (gs_fb !== 32'd0 || bi_mp !== 32'd0) begin
      n_fail++;
      $display("FAIL resweep_counts: got %0d/%0d, expected 0/0",
               gs_fb, bi_mp);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stat_sat();
    test_bimodal();
    test_same_cycle();
    test_gshare_loop();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
